// File: rtl/mdu_if.sv
// Multiply/divide unit request/result bundle between decode and the sequencer.
// The core side drives the request, the sequencer drives HI/LO and status.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative mult/multu/div/divu sequencer owning the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fix-up at the end.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   mq;
    logic [2*WIDTH-1:0] acc;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     dsh;
    logic [WIDTH+1:0]   ddiff;
    logic               ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign rs_neg = bus.op[0] & bus.rs_val[WIDTH-1];
    assign rt_neg = bus.op[0] & bus.rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
    assign rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;

    assign msum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (mq[0] ? b : {WIDTH{1'b0}})};
    assign dsh   = {acc[2*WIDTH-1:WIDTH], mq[WIDTH-1]};
    assign ddiff = {1'b0, dsh} - {2'b00, b};
    assign ge    = ~ddiff[WIDTH+1];

    assign prod = (sa ^ sb) ? -acc : acc;
    assign quo  = (sa ^ sb) ? -mq : mq;
    // With a zero divisor every trial succeeds, so the remainder ends up as
    // the dividend magnitude and this also restores the original rs_val.
    assign rem  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            b      <= '0;
            mq     <= '0;
            acc    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        is_div <= bus.op[1];
                        sa     <= rs_neg;
                        sb     <= rt_neg;
                        mq     <= bus.op[1] ? rs_mag : rt_mag;
                        b      <= bus.op[1] ? rt_mag : rs_mag;
                        acc    <= '0;
                        cnt    <= '0;
                        dz_q   <= 1'b0;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc[2*WIDTH-1:WIDTH] <= ge ? ddiff[WIDTH-1:0]
                                                   : dsh[WIDTH-1:0];
                        mq <= {mq[WIDTH-2:0], ge};
                    end else begin
                        acc <= {msum, acc[WIDTH-1:1]};
                        mq  <= mq >> 1;
                    end
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    if (is_div) begin
                        hi_q <= rem;
                        if (b == '0) begin
                            lo_q <= '1;
                            dz_q <= 1'b1;
                        end else begin
                            lo_q <= quo;
                        end
                    end else begin
                        {hi_q, lo_q} <= prod;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
